// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg -- shared UART constants and receiver state encoding. rev 1.0
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int       CLKS_PER_BIT_DEF = 87;
  localparam int       DATA_BITS        = 8;
  localparam logic     IDLE_LEVEL       = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_sync2 -- two-flop synchronizer for an asynchronous input. rev 1.0
// ---------------------------------------------------------------------------
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver with mid-bit sampling and framing check. rev 1.0
// ---------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx_serial,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte,
  output logic       o_frame_err,
  output logic       o_rx_busy
);

  localparam int             IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [DATA_BITS-1:0] shreg, shreg_n;
  logic [7:0]           byte_n;
  logic                 dv_n, err_n, busy_n;

  uart_sync2 #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_rx_serial),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      o_rx_byte   <= 8'h00;
      o_rx_dv     <= 1'b0;
      o_frame_err <= 1'b0;
      o_rx_busy   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      idx         <= idx_n;
      shreg       <= shreg_n;
      o_rx_byte   <= byte_n;
      o_rx_dv     <= dv_n;
      o_frame_err <= err_n;
      o_rx_busy   <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    byte_n  = o_rx_byte;
    dv_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (rx_s != IDLE_LEVEL) state_n = START;
      end
      START: begin
        // A start bit that is no longer low at its midpoint was a glitch.
        if (cnt == HALF_CNT) begin
          cnt_n   = '0;
          state_n = (rx_s != IDLE_LEVEL) ? DATA : IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_n        = '0;
          shreg_n[idx] = rx_s;
          if (idx == LAST_IDX) state_n = STOP;
          else                 idx_n   = idx + IDX_W'(1);
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == LAST_CNT) begin
          cnt_n   = '0;
          state_n = CLEANUP;
          if (rx_s == IDLE_LEVEL) begin
            byte_n = shreg;
            dv_n   = 1'b1;
          end else begin
            err_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      CLEANUP: begin
        // Hold here through a break until the line is idle again.
        cnt_n = '0;
        if (rx_s == IDLE_LEVEL) state_n = IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receive end of the team's 8N1 UART link. It recovers bytes from the asynchronous serial line driven by the UART transmitter, or by an external device, using mid-bit sampling. Each good byte is presented as a one-cycle valid strobe plus data; malformed frames are flagged. It sits in `top` between the serial pin and the byte-level consumer.

Parameters:
- CLKS_PER_BIT, 87, clk cycles per serial bit (e.g. 10 MHz / 115200). Legal range is 4 or more; the bench uses the default.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-period counter. Derived; not to be overridden.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- i_rx_serial  input  1  asynchronous serial line, idle high
- o_rx_dv  output  1  one-cycle pulse: o_rx_byte holds a newly received good byte
- o_rx_byte  output  8  last good byte; holds until the next good byte
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low
- o_rx_busy  output  1  high from accepted start edge until return to IDLE

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, counters=0.
  - Both synchronizer flops are set to 1 (line idle).
  - o_rx_dv=0, o_frame_err=0, o_rx_busy=0, o_rx_byte=8'h00.
- Reset mid-frame abandons the frame. No dv or err pulse is produced for it.
- Input path: i_rx_serial passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s, so there is 2 cycles of input latency.
- IDLE:
  - Counters are cleared.
  - rx_s==0 -> START, and o_rx_busy goes high on the next cycle.
- START:
  - Count to (CLKS_PER_BIT-1)/2 (43 at default), i.e. the middle of the start bit.
  - If rx_s==0 there -> DATA with counter=0 and bit index=0.
  - Otherwise (glitch) -> IDLE. No flags are raised.
- DATA:
  - Counter runs 0..CLKS_PER_BIT-1. At terminal count, sample rx_s into shift register bit[index].
  - Bits arrive LSB first.
  - After index 7 -> STOP; otherwise index+1.
- STOP:
  - At terminal count, sample rx_s.
  - If rx_s==1: o_rx_byte <= shift register, and o_rx_dv=1 for exactly one cycle.
  - If rx_s==0: o_frame_err=1 for exactly one cycle, and o_rx_byte is unchanged.
  - Then -> CLEANUP.
- CLEANUP:
  - Wait until rx_s==1, which covers a held-low break, then -> IDLE.
  - After a good stop bit this state is left after 1 cycle.
  - o_rx_busy deasserts on entry to IDLE.
- o_rx_dv and o_frame_err are never high in the same cycle.
- Back-to-back frames:
  - A start edge that arrives while still in CLEANUP/IDLE is caught.
  - Total frame cost is about 9.5 bit periods + 2 cycles, so frames are tolerated with no idle gap after the stop bit.
- Latency: o_rx_dv rises about 2 + (CLKS_PER_BIT-1)/2 + 9*CLKS_PER_BIT + 1 cycles after the falling start edge on i_rx_serial. That is about 829 cycles at the default, ±1.
- Counter arithmetic:
  - Unsigned, CNT_W bits, resets to 0 on every state change.
  - It must never wrap past CLKS_PER_BIT-1.
- No oversampling voting. A single mid-bit sample is used per bit.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, CLEANUP);
  - the constants DATA_BITS=8 and IDLE_LEVEL=1'b1;
  - the default CLKS_PER_BIT, shared with the transmitter.
- One sub-module: uart_sync2, a 2-flop synchronizer with a reset value parameter. It is reusable for other async inputs.

Test Plan:
- Loopback: the transmitter sends 8'hBE (i_tx_dv pulse) looped to i_rx_serial -> exactly one o_rx_dv pulse, o_rx_byte=8'hBE, o_frame_err stays 0, all within 9000 ns at a 10 ns clk.
- Back-to-back: bench drives 8'h00, 8'hFF, 8'hA5 with no idle gap -> three dv pulses with bytes 00, FF, A5 in order, and no frame errors.
- Glitch: drive i_rx_serial low for 20 cycles, then high -> no dv, no err, busy returns to 0 before count 44.
- Framing error: send 8'h3C with the stop bit driven low and then held low 3 bit times -> one o_frame_err pulse, o_rx_byte keeps its previous value, no return to IDLE until the line goes high, then a following 8'h55 is received correctly.
- Reset mid-frame: assert rst for 1 cycle during data bit 4 of 8'hC3 -> outputs are at reset values the next cycle, no dv for that frame, and the next frame 8'h81 is received correctly.
- Timing margin: drive bits at CLKS_PER_BIT±3 cycles per bit -> 8'hBE is still received correctly.
